// File: rtl/tinyalu_pkg.sv
// Opcode and controller-state types shared by the ALU command driver.
// Nothing here depends on the operand width.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    ALU_RST,
    RESP
  } state_t;

  // 101 and 110 are reserved encodings and behave as no_op
  function automatic operation_t norm_op(input logic [2:0] op);
    operation_t o;
    unique case (op)
      3'b101, 3'b110: o = no_op;
      default:        o = operation_t'(op);
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command, ALU-side and response signals of the ALU command driver.
// master = driver view, slave = environment view.
interface alu_cmd_driver_if #(
  parameter int DATA_W = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;
  logic [2:0]          cmd_op;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [2:0]          alu_op;
  logic                alu_start;
  logic                alu_reset_n;
  logic                alu_done;
  logic [2*DATA_W-1:0] alu_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2*DATA_W-1:0] rsp_result;
  logic [2:0]          rsp_op;
  logic                rsp_timeout;
  logic [15:0]         ops_issued;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op,
    output alu_start, alu_reset_n,
    output rsp_valid, rsp_result, rsp_op,
    output rsp_timeout, ops_issued
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op,
    input  alu_start, alu_reset_n,
    input  rsp_valid, rsp_result, rsp_op,
    input  rsp_timeout, ops_issued
  );
endinterface

// File: rtl/alu_cmd_driver_fifo.sv
// Command FIFO: power-of-two depth, wrap-bit pointers.
// Push is ignored while full, pop while empty.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/alu_cmd_driver.sv
// Queues ALU commands and sequences them one at a time onto a
// start/done ALU, returning each result through a response handshake.
module alu_cmd_driver
  import tinyalu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  alu_cmd_driver_if.master bus
);
  localparam int FW = 2*DATA_W + 3;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  operation_t          op_q, op_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                tmo_q, tmo_d;
  logic                rstn_q, rstn_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         ops_q, ops_d;

  logic              push, pop, full, empty;
  logic [FW-1:0]     wdata, rdata;
  logic [DATA_W-1:0] h_a, h_b;
  logic [2:0]        h_op;

  assign wdata = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  assign {h_op, h_a, h_b} = rdata;
  assign push = bus.cmd_valid & ~full;
  assign pop  = (state_q == IDLE) & ~empty;

  alu_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= no_op;
      res_q   <= '0;
      tmo_q   <= 1'b0;
      rstn_q  <= 1'b0;
      cnt_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      rstn_q  <= rstn_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          a_d     = h_a;
          b_d     = h_b;
          op_d    = norm_op(h_op);
          res_d   = '0;
          tmo_d   = 1'b0;
          cnt_d   = '0;
          state_d = (op_d == rst_op) ? ALU_RST : ISSUE;
        end
      end
      ISSUE: state_d = (op_q == no_op) ? RESP : WAIT_DONE;
      WAIT_DONE: begin
        // done wins over an expiry landing on the same cycle
        if (bus.alu_done) begin
          res_d   = bus.alu_result;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          res_d   = '0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ALU_RST: begin
        if (cnt_q == CW'(1)) state_d = IDLE;
        else                 cnt_d   = cnt_q + CW'(1);
      end
      RESP: begin
        if (bus.rsp_ready) begin
          ops_d   = ops_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // registered so it stays low through reset and rises one cycle after
    rstn_d = state_d != ALU_RST;
  end

  always_comb begin
    bus.cmd_ready   = ~full;
    bus.alu_a       = a_q;
    bus.alu_b       = b_q;
    bus.alu_op      = op_q;
    bus.alu_start   = (state_q == ISSUE) || (state_q == WAIT_DONE);
    bus.alu_reset_n = rstn_q;
    bus.rsp_valid   = state_q == RESP;
    bus.rsp_result  = res_q;
    bus.rsp_op      = op_q;
    bus.rsp_timeout = tmo_q;
    bus.ops_issued  = ops_q;
  end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a latency-programmable ALU stub.
// Expected responses are queued at command acceptance and matched on response.
module tb_alu_cmd_driver;
  import tinyalu_pkg::*;

  localparam int DW = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_driver_if #(.DATA_W(DW)) bus();

  alu_cmd_driver #(
    .DATA_W      (DW),
    .DEPTH       (4),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic [2:0]  op;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int lat = 1;
  int scnt = 0;
  int exp_ops = 0, acc = 0, rsp_cnt = 0;
  int srun = 0, last_srun = 0, rrun = 0, last_rrun = 0;
  int start_total = 0;
  logic rdy_rand = 1'b0, rdy_fix = 1'b1, rnd_rdy = 1'b0;

  function automatic logic [15:0] alu_f(input logic [7:0] a, b,
                                        input logic [2:0] op);
    logic [15:0] r;
    case (op)
      3'd1:    r = {8'h00, a} + {8'h00, b};
      3'd2:    r = {8'h00, a & b};
      3'd3:    r = {8'h00, a ^ b};
      3'd4:    r = {8'h00, a} * {8'h00, b};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ALU stub: done in the (lat+1)-th cycle of a continuous start pulse
  always @(posedge clk) scnt <= bus.alu_start ? scnt + 1 : 0;
  assign bus.alu_done   = bus.alu_start && (scnt == lat);
  assign bus.alu_result = bus.alu_done ?
                          alu_f(bus.alu_a, bus.alu_b, bus.alu_op) : 16'hDEAD;
  assign bus.rsp_ready  = rdy_rand ? rnd_rdy : rdy_fix;

  initial forever begin
    @(posedge clk); #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  logic        stall = 1'b0;
  logic [15:0] p_res;
  logic [2:0]  p_op;
  logic        p_tmo;

  always @(negedge clk) begin : mon
    exp_t e;
    logic [2:0] nop;
    if (reset) begin
      sb.delete();
      exp_ops = 0;
      srun = 0;
      rrun = 0;
      stall = 1'b0;
    end else begin
      chk("ops_issued", bus.ops_issued, exp_ops);
      if (stall) begin
        chk("hold_valid", bus.rsp_valid, 1);
        chk("hold_result", bus.rsp_result, p_res);
        chk("hold_op", bus.rsp_op, p_op);
        chk("hold_timeout", bus.rsp_timeout, p_tmo);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc++;
        nop = (bus.cmd_op == 3'd5 || bus.cmd_op == 3'd6) ? 3'd0 : bus.cmd_op;
        if (nop != 3'd7) begin
          e.op  = nop;
          e.tmo = (nop >= 3'd1 && nop <= 3'd4) && (lat < 1 || lat > TO);
          e.res = e.tmo ? 16'h0 : alu_f(bus.cmd_a, bus.cmd_b, nop);
          sb.push_back(e);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_cnt++;
        exp_ops = (exp_ops + 1) % 65536;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got result %0h want none",
                   bus.rsp_result);
        end else begin
          e = sb.pop_front();
          chk("rsp_result", bus.rsp_result, e.res);
          chk("rsp_op", bus.rsp_op, e.op);
          chk("rsp_timeout", bus.rsp_timeout, e.tmo);
        end
      end
      stall = bus.rsp_valid && !bus.rsp_ready;
      p_res = bus.rsp_result;
      p_op  = bus.rsp_op;
      p_tmo = bus.rsp_timeout;
      if (bus.alu_start) begin
        srun++;
        start_total++;
      end else if (srun != 0) begin
        last_srun = srun;
        srun = 0;
      end
      if (!bus.alu_reset_n) rrun++;
      else if (rrun != 0) begin
        last_rrun = rrun;
        rrun = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] a, b, input logic [2:0] op);
    int n = 0;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 500) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) begin
      total++;
      bad++;
      $display("FAIL send_wait: got cmd_ready 0 want 1");
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int idle = 0, n = 0;
    while (idle < 4 && n < 3000) begin
      tick();
      n++;
      if (sb.size() == 0 && !bus.rsp_valid && !bus.alu_start &&
          bus.alu_reset_n)
        idle++;
      else
        idle = 0;
    end
    if (idle < 4) begin
      total++;
      bad++;
      $display("FAIL drain_%s: got busy want idle", name);
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({t, "_alu_start"}, bus.alu_start, 0);
    chk({t, "_alu_reset_n"}, bus.alu_reset_n, 0);
    chk({t, "_alu_a"}, bus.alu_a, 0);
    chk({t, "_alu_b"}, bus.alu_b, 0);
    chk({t, "_alu_op"}, bus.alu_op, 0);
    chk({t, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({t, "_rsp_result"}, bus.rsp_result, 0);
    chk({t, "_rsp_timeout"}, bus.rsp_timeout, 0);
    chk({t, "_ops"}, bus.ops_issued, 0);
  endtask

  initial begin : watchdog
    #600000;
    total++;
    bad++;
    $display("FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int r0, o0, a0, s0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    repeat (3) tick();
    @(negedge clk);
    chk_reset("init");
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstn_still_low", bus.alu_reset_n, 0);
    tick();
    chk("rstn_rise", bus.alu_reset_n, 1);

    lat = 1;
    send(8'hFF, 8'h01, 3'd1);
    drain("add");
    chk("add_start_len", last_srun, 2);
    chk("add_ops", bus.ops_issued, 1);

    lat = 3;
    send(8'hFF, 8'hFF, 3'd4);
    drain("mul");
    chk("mul_start_len", last_srun, 4);
    chk("mul_ops", bus.ops_issued, 2);

    r0 = rsp_cnt;
    o0 = int'(bus.ops_issued);
    send(8'h12, 8'h34, 3'd7);
    drain("rst");
    chk("rst_low_len", last_rrun, 2);
    chk("rst_no_rsp", rsp_cnt, r0);
    chk("rst_ops", bus.ops_issued, o0);

    send(8'h03, 8'h04, 3'd0);
    drain("noop");
    chk("noop_start_len", last_srun, 1);
    send(8'h55, 8'h66, 3'd5);
    drain("op101");

    lat = 1000;
    send(8'hA5, 8'h5A, 3'd3);
    drain("timeout");
    chk("tmo_start_len", last_srun, TO + 1);

    lat = 1;
    rdy_fix = 1'b0;
    a0 = acc;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_a = 8'(i + 1);
      bus.cmd_b = 8'(3 * i);
      bus.cmd_op = (i % 2 == 0) ? 3'd1 : 3'd4;
      bus.cmd_valid = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    chk("fifo_accepted", acc - a0, 5);
    repeat (3) tick();
    chk("fifo_ready_low", bus.cmd_ready, 0);
    rdy_fix = 1'b1;
    drain("fifo");

    lat = 1000;
    send(8'h01, 8'h02, 3'd3);
    send(8'h03, 8'h04, 3'd1);
    send(8'h05, 8'h06, 3'd4);
    repeat (5) tick();
    chk("midop_busy", bus.alu_start, 1);
    reset = 1'b1;
    tick();
    chk_reset("midop");
    tick();
    reset = 1'b0;
    s0 = start_total;
    r0 = rsp_cnt;
    repeat (100) tick();
    chk("midop_no_start", start_total - s0, 0);
    chk("midop_no_rsp", rsp_cnt - r0, 0);

    rdy_rand = 1'b1;
    for (int b = 0; b < 5; b++) begin
      lat = (b == 2) ? 0 : int'($urandom_range(1, 6));
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      end
      drain("random");
    end
    rdy_rand = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 Parameter DATA_W, default 8, operand width; result width is 2*DATA_W.
REQ-002 Parameter DEPTH, default 4, command FIFO entries, power of two, >=2.
REQ-003 Parameter TIMEOUT_CYC, default 64, max cycles start stays high awaiting done.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both high.
REQ-007 cmd_a, cmd_b  in  DATA_W  operands; cmd_op  in  3  operation_t.
REQ-008 alu_a, alu_b  out  DATA_W; alu_op  out  3; alu_start  out  1; alu_reset_n  out  1  ALU-side drive.
REQ-009 alu_done  in  1; alu_result  in  2*DATA_W  ALU-side return.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-011 rsp_result  out  2*DATA_W; rsp_op  out  3; rsp_timeout  out  1.
REQ-012 ops_issued  out  16  count of completed non-reset operations, wraps at 16'hFFFF->0.

Function
REQ-013 Opcodes: no_op=3'b000, add_op=001, and_op=010, xor_op=011, mul_op=100, rst_op=111; 101/110 treated as no_op.
REQ-014 Commands SHALL enter a DEPTH-entry FIFO; cmd_ready = FIFO not full; simultaneous push and pop when full SHALL NOT be allowed (ready low blocks push).
REQ-015 States: IDLE, ISSUE, WAIT_DONE, ALU_RST, RESP.
REQ-016 IDLE: FIFO non-empty -> pop head into operand/op registers, go to ISSUE (rst_op -> ALU_RST).
REQ-017 ISSUE: alu_a/alu_b/alu_op driven from registers, alu_start=1 for exactly this cycle if op is no_op (then RESP with rsp_result=0), else go WAIT_DONE with alu_start held 1.
REQ-018 WAIT_DONE: alu_start stays 1 and operands stable; alu_done=1 sampled -> capture alu_result, alu_start=0 next cycle, go RESP.
REQ-019 Timeout: TIMEOUT_CYC cycles in WAIT_DONE without done -> alu_start=0, rsp_result=0, rsp_timeout=1, go RESP.
REQ-020 ALU_RST: alu_reset_n=0 for exactly 2 cycles, alu_start=0, then IDLE; no response generated, ops_issued unchanged.
REQ-021 RESP: rsp_valid=1 with rsp_result/rsp_op/rsp_timeout stable until rsp_ready; on transfer ops_issued increments, go IDLE.
REQ-022 Latency: command popped in IDLE at cycle N -> alu_start first high at N+1; done sampled at M -> rsp_valid at M+1.
REQ-023 alu_done while not in WAIT_DONE SHALL be ignored.
REQ-024 At most one ALU operation outstanding; FIFO continues accepting during any state.

Reset
REQ-025 On reset: FIFO empty, state IDLE, cmd_ready=1, alu_start=0, alu_reset_n=0, alu_a/alu_b/alu_op=0, rsp_valid=0, rsp_result=0, rsp_timeout=0, ops_issued=0.
REQ-026 alu_reset_n SHALL rise the first cycle after reset deasserts.
REQ-027 Reset mid-operation SHALL abandon the in-flight op and all queued commands with no response.

Structure
REQ-028 operation_t and opcode constants SHALL live in tinyalu_pkg; DATA_W-independent.
REQ-029 The command FIFO SHALL be a sub-module alu_cmd_fifo #(WIDTH, DEPTH) with push/pop/full/empty.

Verification
REQ-030 add_op A=8'hFF B=8'h01, ALU done after 1 cycle -> rsp_result=16'h0100, rsp_timeout=0, ops_issued=1.
REQ-031 mul_op A=8'hFF B=8'hFF, done after 3 cycles -> alu_start high 4 cycles, rsp_result=16'hFE01.
REQ-032 rst_op -> alu_reset_n low exactly 2 cycles, no rsp_valid, ops_issued unchanged.
REQ-033 xor_op with alu_done held 0 -> alu_start drops after 64 cycles, rsp_timeout=1, rsp_result=0.
REQ-034 DEPTH=4, rsp_ready=0, push 6 commands back-to-back -> 5 accepted (1 popped, 4 queued), cmd_ready low thereafter.
REQ-035 Reset asserted during WAIT_DONE with 2 queued -> all outputs at reset values next cycle, no response ever emitted.
